// File: rtl/cr_huf_compPKG.sv
// rtl/cr_huf_compPKG.sv - huffman compressor shared types for the seq_id table and its allocator
`ifndef CREOLE_HC_SEQID_NUM
`define CREOLE_HC_SEQID_NUM 8
`endif
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 3
`endif

package cr_huf_compPKG;

    localparam int HC_SEQID_NUM       = `CREOLE_HC_SEQID_NUM;
    localparam int HC_SEQID_WIDTH     = `CREOLE_HC_SEQID_WIDTH;
    localparam int HC_SEQID_RAW_CRC_W = 32;

    typedef enum logic [1:0] {IDLE, WR, OPEN, CRC} e_seq_id_alloc_st;

    typedef enum logic [1:0] {CHU4K, CHU8K, XP9, XP10} e_comp_mode;

    typedef struct packed {
        e_comp_mode                      comp_mode;
        logic [3:0]                      lz77_win_size;
        logic                            xp10_prefix_mode;
        logic [HC_SEQID_RAW_CRC_W-1:0]   raw_crc;
    } s_sm_seq_id_intf;

    typedef struct packed {
        logic                            vld;
        logic                            vld_crc;
        logic                            vld_stats;
        logic [HC_SEQID_WIDTH-1:0]       seq_id;
    } s_sm_seq_id_wr_intf;

    typedef struct packed {
        logic                            vld;
        logic [HC_SEQID_WIDTH-1:0]       seq_id;
    } s_sa_sm_intf;

endpackage

// File: rtl/cr_huf_comp_seq_id_alloc_stats.sv
// rtl/cr_huf_comp_seq_id_alloc_stats.sv - saturating frame and full-stall counters
module cr_huf_comp_seq_id_alloc_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frm_alloc,
    input  logic        full_stall,
    output logic [31:0] stat_frm_cnt,
    output logic [31:0] stat_full_cyc
);

    logic [31:0] frm_cnt_q, frm_cnt_d;
    logic [31:0] full_cyc_q, full_cyc_d;

    always_comb begin
        frm_cnt_d  = frm_cnt_q;
        full_cyc_d = full_cyc_q;
        if (frm_alloc && (frm_cnt_q != 32'hFFFF_FFFF))
            frm_cnt_d = frm_cnt_q + 32'd1;
        if (full_stall && (full_cyc_q != 32'hFFFF_FFFF))
            full_cyc_d = full_cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt_q  <= '0;
            full_cyc_q <= '0;
        end else begin
            frm_cnt_q  <= frm_cnt_d;
            full_cyc_q <= full_cyc_d;
        end
    end

    assign stat_frm_cnt  = frm_cnt_q;
    assign stat_full_cyc = full_cyc_q;

endmodule

// File: rtl/cr_huf_comp_seq_id_alloc.sv
// rtl/cr_huf_comp_seq_id_alloc.sv - seq_id ring allocator/retirer; CR_HUF_COMP_SEQ_ID_ALLOC_STATS_EN adds stat counters
module cr_huf_comp_seq_id_alloc
    import cr_huf_compPKG::*;
#(
    parameter int SEQ_ID_NUM   = `CREOLE_HC_SEQID_NUM,
    parameter int SEQ_ID_WIDTH = `CREOLE_HC_SEQID_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frm_req_vld,
    output logic                     frm_req_rdy,
    input  s_sm_seq_id_intf          frm_req_cfg,
    input  logic                     frm_crc_vld,
    output logic                     frm_crc_rdy,
    input  logic [31:0]              frm_crc,
    output s_sm_seq_id_wr_intf       sm_seq_id_wr_intf,
    output s_sm_seq_id_intf          sm_seq_id_intf,
    input  s_sa_sm_intf              sa_sm_intf,
    output logic [SEQ_ID_WIDTH-1:0]  cur_seq_id,
    output logic [SEQ_ID_WIDTH:0]    inflight_cnt,
    output logic                     seq_id_err
`ifdef CR_HUF_COMP_SEQ_ID_ALLOC_STATS_EN
    ,
    output logic [31:0]              stat_frm_cnt,
    output logic [31:0]              stat_full_cyc
`endif
);

    localparam logic [SEQ_ID_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [SEQ_ID_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [SEQ_ID_WIDTH:0]   CNT_FULL = SEQ_ID_NUM[SEQ_ID_WIDTH:0];

    e_seq_id_alloc_st          state_q, state_d;
    logic [SEQ_ID_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [SEQ_ID_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [SEQ_ID_WIDTH:0]     inflight_q, inflight_d;
    logic [SEQ_ID_WIDTH-1:0]   seq_id_q, seq_id_d;
    logic [SEQ_ID_WIDTH-1:0]   cur_seq_id_q, cur_seq_id_d;
    s_sm_seq_id_intf           cfg_q, cfg_d;
    logic                      wr_vld_q, wr_vld_d;
    logic                      wr_vld_crc_q, wr_vld_crc_d;
    logic                      err_q, err_d;
    logic                      run_q;

    logic req_acc;
    logic crc_acc;
    logic retire_ok;

    // run_q keeps the request side closed while reset is asserted
    assign frm_req_rdy = run_q && (state_q == IDLE) && (inflight_q < CNT_FULL);
    assign frm_crc_rdy = (state_q == OPEN);
    assign req_acc     = frm_req_vld && frm_req_rdy;
    assign crc_acc     = frm_crc_vld && frm_crc_rdy;

    // The open frame's id is held in seq_id_q while the FSM is outside IDLE
    assign retire_ok = sa_sm_intf.vld && (inflight_q != '0) &&
                       (sa_sm_intf.seq_id == rd_ptr_q) &&
                       !((state_q != IDLE) && (sa_sm_intf.seq_id == seq_id_q));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        seq_id_d     = seq_id_q;
        cur_seq_id_d = cur_seq_id_q;
        cfg_d        = cfg_q;
        wr_vld_d     = 1'b0;
        wr_vld_crc_d = 1'b0;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (req_acc) begin
                    state_d       = WR;
                    wr_vld_d      = 1'b1;
                    seq_id_d      = wr_ptr_q;
                    cur_seq_id_d  = wr_ptr_q;
                    cfg_d         = frm_req_cfg;
                    cfg_d.raw_crc = '0;
                    wr_ptr_d      = wr_ptr_q + PTR_ONE;
                end
            end
            WR:   state_d = OPEN;
            OPEN: begin
                if (crc_acc) begin
                    state_d       = CRC;
                    wr_vld_crc_d  = 1'b1;
                    cfg_d.raw_crc = frm_crc;
                end
            end
            CRC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (retire_ok)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        else if (sa_sm_intf.vld)
            err_d = 1'b1;

        inflight_d = inflight_q + (req_acc ? CNT_ONE : '0) - (retire_ok ? CNT_ONE : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inflight_q   <= '0;
            seq_id_q     <= '0;
            cur_seq_id_q <= '0;
            cfg_q        <= '0;
            wr_vld_q     <= 1'b0;
            wr_vld_crc_q <= 1'b0;
            err_q        <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            seq_id_q     <= seq_id_d;
            cur_seq_id_q <= cur_seq_id_d;
            cfg_q        <= cfg_d;
            wr_vld_q     <= wr_vld_d;
            wr_vld_crc_q <= wr_vld_crc_d;
            err_q        <= err_d;
            run_q        <= 1'b1;
        end
    end

    always_comb begin
        sm_seq_id_wr_intf         = '0;
        sm_seq_id_wr_intf.vld     = wr_vld_q;
        sm_seq_id_wr_intf.vld_crc = wr_vld_crc_q;
        sm_seq_id_wr_intf.seq_id  = seq_id_q;
    end

    assign sm_seq_id_intf = cfg_q;
    assign cur_seq_id     = cur_seq_id_q;
    assign inflight_cnt   = inflight_q;
    assign seq_id_err     = err_q;

`ifdef CR_HUF_COMP_SEQ_ID_ALLOC_STATS_EN
    cr_huf_comp_seq_id_alloc_stats u_stats (
        .clk           (clk),
        .rst_n         (rst_n),
        .frm_alloc     (req_acc),
        .full_stall    (frm_req_vld && !frm_req_rdy && (state_q == IDLE)),
        .stat_frm_cnt  (stat_frm_cnt),
        .stat_full_cyc (stat_full_cyc)
    );
`endif

endmodule

// File: tb/tb_cr_huf_comp_seq_id_alloc.sv
// tb/tb_cr_huf_comp_seq_id_alloc.sv - directed self-checking bench for the seq_id allocator (SEQ_ID_NUM=8)
module tb_cr_huf_comp_seq_id_alloc;
    import cr_huf_compPKG::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frm_req_vld;
    logic               frm_req_rdy;
    s_sm_seq_id_intf    frm_req_cfg;
    logic               frm_crc_vld;
    logic               frm_crc_rdy;
    logic [31:0]        frm_crc;
    s_sm_seq_id_wr_intf sm_seq_id_wr_intf;
    s_sm_seq_id_intf    sm_seq_id_intf;
    s_sa_sm_intf        sa_sm_intf;
    logic [2:0]         cur_seq_id;
    logic [3:0]         inflight_cnt;
    logic               seq_id_err;
`ifdef CR_HUF_COMP_SEQ_ID_ALLOC_STATS_EN
    logic [31:0]        stat_frm_cnt;
    logic [31:0]        stat_full_cyc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cr_huf_comp_seq_id_alloc #(.SEQ_ID_NUM(8), .SEQ_ID_WIDTH(3)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frm_req_vld       (frm_req_vld),
        .frm_req_rdy       (frm_req_rdy),
        .frm_req_cfg       (frm_req_cfg),
        .frm_crc_vld       (frm_crc_vld),
        .frm_crc_rdy       (frm_crc_rdy),
        .frm_crc           (frm_crc),
        .sm_seq_id_wr_intf (sm_seq_id_wr_intf),
        .sm_seq_id_intf    (sm_seq_id_intf),
        .sa_sm_intf        (sa_sm_intf),
        .cur_seq_id        (cur_seq_id),
        .inflight_cnt      (inflight_cnt),
        .seq_id_err        (seq_id_err)
`ifdef CR_HUF_COMP_SEQ_ID_ALLOC_STATS_EN
        ,
        .stat_frm_cnt      (stat_frm_cnt),
        .stat_full_cyc     (stat_full_cyc)
`endif
    );

    task automatic do_reset();
        rst_n       = 1'b0;
        frm_req_vld = 1'b0;
        frm_req_cfg = '0;
        frm_crc_vld = 1'b0;
        frm_crc     = '0;
        sa_sm_intf  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the accepting edge, i.e. in the WR cycle
    task automatic send_req(input e_comp_mode mode);
        bit ok = 1'b0;
        frm_req_cfg           = '0;
        frm_req_cfg.comp_mode = mode;
        frm_req_cfg.raw_crc   = 32'hFFFF_FFFF;
        frm_req_vld           = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frm_req_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL req_timeout: frm_req_rdy=%0b required 1 within 40 cycles", frm_req_rdy); end
        @(posedge clk);
        #1 frm_req_vld = 1'b0;
    endtask

    // Returns #1 after the accepting edge, i.e. in the CRC cycle
    task automatic send_crc(input logic [31:0] crc);
        bit ok = 1'b0;
        frm_crc     = crc;
        frm_crc_vld = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frm_crc_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL crc_timeout: frm_crc_rdy=%0b required 1 within 40 cycles", frm_crc_rdy); end
        @(posedge clk);
        #1 frm_crc_vld = 1'b0;
    endtask

    task automatic retire(input logic [2:0] id);
        sa_sm_intf.vld    = 1'b1;
        sa_sm_intf.seq_id = id;
        @(posedge clk);
        #1 sa_sm_intf = '0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        frm_req_vld = 1'b0;
        frm_req_cfg = '0;
        frm_crc_vld = 1'b0;
        frm_crc     = '0;
        sa_sm_intf  = '0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (sm_seq_id_wr_intf !== '0) begin n_fail++; $display("FAIL rst_wr_intf: got %h required 0", sm_seq_id_wr_intf); end
        n_checks++; if (sm_seq_id_intf !== '0) begin n_fail++; $display("FAIL rst_sm_intf: got %h required 0", sm_seq_id_intf); end
        n_checks++; if (inflight_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_inflight: got %0d required 0", inflight_cnt); end
        n_checks++; if (cur_seq_id !== 3'd0) begin n_fail++; $display("FAIL rst_cur_seq_id: got %0d required 0", cur_seq_id); end
        n_checks++; if (seq_id_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b required 0", seq_id_err); end
        n_checks++; if (frm_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy: got %0b required 0", frm_req_rdy); end
        n_checks++; if (frm_crc_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_crc_rdy: got %0b required 0", frm_crc_rdy); end
        do_reset();
        n_checks++; if (frm_req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_rdy: got %0b required 1", frm_req_rdy); end
    endtask

    task automatic test_single_frame();
        do_reset();
        send_req(XP10);
        n_checks++; if (sm_seq_id_wr_intf.vld !== 1'b1) begin n_fail++; $display("FAIL single_wr_vld: got %0b required 1", sm_seq_id_wr_intf.vld); end
        n_checks++; if (sm_seq_id_wr_intf.seq_id !== 3'd0) begin n_fail++; $display("FAIL single_wr_seq_id: got %0d required 0", sm_seq_id_wr_intf.seq_id); end
        n_checks++; if (cur_seq_id !== 3'd0) begin n_fail++; $display("FAIL single_cur_seq_id: got %0d required 0", cur_seq_id); end
        n_checks++; if (inflight_cnt !== 4'd1) begin n_fail++; $display("FAIL single_inflight: got %0d required 1", inflight_cnt); end
        n_checks++; if (sm_seq_id_intf.comp_mode !== XP10) begin n_fail++; $display("FAIL single_comp_mode: got %0d required %0d", sm_seq_id_intf.comp_mode, XP10); end
        n_checks++; if (sm_seq_id_intf.raw_crc !== 32'h0) begin n_fail++; $display("FAIL single_raw_crc_wr: got %h required 0", sm_seq_id_intf.raw_crc); end
        send_crc(32'hDEADBEEF);
        n_checks++; if (sm_seq_id_wr_intf.vld_crc !== 1'b1) begin n_fail++; $display("FAIL single_vld_crc: got %0b required 1", sm_seq_id_wr_intf.vld_crc); end
        n_checks++; if (sm_seq_id_wr_intf.vld !== 1'b0) begin n_fail++; $display("FAIL single_wr_vld_drop: got %0b required 0", sm_seq_id_wr_intf.vld); end
        n_checks++; if (sm_seq_id_intf.raw_crc !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_raw_crc: got %h required deadbeef", sm_seq_id_intf.raw_crc); end
        n_checks++; if (sm_seq_id_wr_intf.seq_id !== 3'd0) begin n_fail++; $display("FAIL single_crc_seq_id: got %0d required 0", sm_seq_id_wr_intf.seq_id); end
        @(posedge clk);
        #1;
        n_checks++; if (sm_seq_id_wr_intf.vld_crc !== 1'b0) begin n_fail++; $display("FAIL single_vld_crc_drop: got %0b required 0", sm_seq_id_wr_intf.vld_crc); end
        n_checks++; if (sm_seq_id_intf.raw_crc !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_raw_crc_hold: got %h required deadbeef", sm_seq_id_intf.raw_crc); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_req(XP9);
            n_checks++; if (sm_seq_id_wr_intf.seq_id !== 3'(i)) begin n_fail++; $display("FAIL fill_seq_id_%0d: got %0d required %0d", i, sm_seq_id_wr_intf.seq_id, i); end
            send_crc(32'h1000 + 32'(i));
        end
        @(posedge clk);
        #1;
        n_checks++; if (inflight_cnt !== 4'd8) begin n_fail++; $display("FAIL fill_inflight: got %0d required 8", inflight_cnt); end
        n_checks++; if (frm_req_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_req_rdy: got %0b required 0", frm_req_rdy); end
`ifdef CR_HUF_COMP_SEQ_ID_ALLOC_STATS_EN
        frm_req_vld = 1'b1;
        repeat (10) @(posedge clk);
        #1 frm_req_vld = 1'b0;
        n_checks++; if (stat_full_cyc !== 32'd10) begin n_fail++; $display("FAIL stat_full_cyc: got %0d required 10", stat_full_cyc); end
        n_checks++; if (stat_frm_cnt !== 32'd8) begin n_fail++; $display("FAIL stat_frm_cnt_8: got %0d required 8", stat_frm_cnt); end
`endif
        sa_sm_intf.vld    = 1'b1;
        sa_sm_intf.seq_id = 3'd0;
        @(negedge clk);
        n_checks++; if (frm_req_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_rdy_not_comb: got %0b required 0", frm_req_rdy); end
        @(posedge clk);
        #1 sa_sm_intf = '0;
        n_checks++; if (frm_req_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_rdy_after_retire: got %0b required 1", frm_req_rdy); end
        n_checks++; if (inflight_cnt !== 4'd7) begin n_fail++; $display("FAIL fill_inflight_7: got %0d required 7", inflight_cnt); end
        send_req(CHU4K);
        n_checks++; if (sm_seq_id_wr_intf.seq_id !== 3'd0) begin n_fail++; $display("FAIL fill_wrap_seq_id: got %0d required 0", sm_seq_id_wr_intf.seq_id); end
        n_checks++; if (inflight_cnt !== 4'd8) begin n_fail++; $display("FAIL fill_inflight_refull: got %0d required 8", inflight_cnt); end
        send_crc(32'h0BAD_F00D);
`ifdef CR_HUF_COMP_SEQ_ID_ALLOC_STATS_EN
        n_checks++; if (stat_frm_cnt !== 32'd9) begin n_fail++; $display("FAIL stat_frm_cnt_9: got %0d required 9", stat_frm_cnt); end
`endif
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_req(XP10);
            send_crc(32'(i));
        end
        @(posedge clk);
        #1;
        retire(3'd0);
        n_checks++; if (inflight_cnt !== 4'd3) begin n_fail++; $display("FAIL same_pre_inflight: got %0d required 3", inflight_cnt); end
        frm_req_cfg           = '0;
        frm_req_cfg.comp_mode = XP9;
        frm_req_vld           = 1'b1;
        sa_sm_intf.vld        = 1'b1;
        sa_sm_intf.seq_id     = 3'd1;
        @(posedge clk);
        #1;
        frm_req_vld = 1'b0;
        sa_sm_intf  = '0;
        n_checks++; if (inflight_cnt !== 4'd3) begin n_fail++; $display("FAIL same_inflight: got %0d required 3", inflight_cnt); end
        n_checks++; if (sm_seq_id_wr_intf.vld !== 1'b1 || sm_seq_id_wr_intf.seq_id !== 3'd4) begin n_fail++; $display("FAIL same_alloc: got vld=%0b id=%0d required vld=1 id=4", sm_seq_id_wr_intf.vld, sm_seq_id_wr_intf.seq_id); end
        n_checks++; if (seq_id_err !== 1'b0) begin n_fail++; $display("FAIL same_err: got %0b required 0", seq_id_err); end
        send_crc(32'h5555_AAAA);
        @(posedge clk);
        #1;
        retire(3'd2);
        n_checks++; if (seq_id_err !== 1'b0 || inflight_cnt !== 4'd2) begin n_fail++; $display("FAIL same_rd_ptr: got err=%0b cnt=%0d required err=0 cnt=2", seq_id_err, inflight_cnt); end
        send_req(XP10);
        n_checks++; if (sm_seq_id_wr_intf.seq_id !== 3'd5) begin n_fail++; $display("FAIL same_wr_ptr: got %0d required 5", sm_seq_id_wr_intf.seq_id); end
        send_crc(32'h1);
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_req(XP10);
            send_crc(32'(i));
        end
        @(posedge clk);
        #1;
        retire(3'd2);
        n_checks++; if (seq_id_err !== 1'b1) begin n_fail++; $display("FAIL ooo_err: got %0b required 1", seq_id_err); end
        n_checks++; if (inflight_cnt !== 4'd3) begin n_fail++; $display("FAIL ooo_inflight: got %0d required 3", inflight_cnt); end
        retire(3'd0);
        n_checks++; if (seq_id_err !== 1'b1 || inflight_cnt !== 4'd2) begin n_fail++; $display("FAIL ooo_sticky: got err=%0b cnt=%0d required err=1 cnt=2", seq_id_err, inflight_cnt); end
        do_reset();
        send_req(XP10);
        retire(3'd0);
        n_checks++; if (seq_id_err !== 1'b1) begin n_fail++; $display("FAIL open_retire_err: got %0b required 1", seq_id_err); end
        n_checks++; if (inflight_cnt !== 4'd1) begin n_fail++; $display("FAIL open_retire_inflight: got %0d required 1", inflight_cnt); end
        send_crc(32'h2);
        do_reset();
        retire(3'd0);
        n_checks++; if (seq_id_err !== 1'b1 || inflight_cnt !== 4'd0) begin n_fail++; $display("FAIL empty_retire: got err=%0b cnt=%0d required err=1 cnt=0", seq_id_err, inflight_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_req(CHU8K);
            send_crc(32'hA0 + 32'(i));
        end
        send_req(XP10);
        @(posedge clk);
        #1;
        n_checks++; if (inflight_cnt !== 4'd5 || frm_crc_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got cnt=%0d crc_rdy=%0b required cnt=5 crc_rdy=1", inflight_cnt, frm_crc_rdy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (inflight_cnt !== 4'd0 || cur_seq_id !== 3'd0 || seq_id_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_regs: got cnt=%0d cur=%0d err=%0b required all 0", inflight_cnt, cur_seq_id, seq_id_err); end
        n_checks++; if (sm_seq_id_wr_intf !== '0 || sm_seq_id_intf !== '0) begin n_fail++; $display("FAIL mid_rst_intf: got wr=%h sm=%h required 0", sm_seq_id_wr_intf, sm_seq_id_intf); end
        n_checks++; if (frm_req_rdy !== 1'b0 || frm_crc_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rdy: got req=%0b crc=%0b required 0", frm_req_rdy, frm_crc_rdy); end
        do_reset();
        send_req(XP9);
        n_checks++; if (sm_seq_id_wr_intf.seq_id !== 3'd0 || inflight_cnt !== 4'd1) begin n_fail++; $display("FAIL mid_next_id: got id=%0d cnt=%0d required id=0 cnt=1", sm_seq_id_wr_intf.seq_id, inflight_cnt); end
        send_crc(32'h3);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fill();
        test_same_cycle();
        test_out_of_order();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
